// File: rtl/maze_pkg.sv
// Constants and types shared by the maze controller and the frame painter.
package maze_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAY,
    S_READ,
    S_WAIT,
    S_RELEASE,
    S_WIN
  } maze_state_t;

  localparam int          ROM_STRIDE    = 64;   // blocks per ROM row (power of two)
  localparam int          VIS_BCOLS     = 40;   // visible block columns
  localparam int          PLAY_BROWS    = 29;   // playable rows; row 29 is the timer bar
  localparam int          BLOCK_SHIFT   = 4;    // colour lives above this bit in a ROM word
  localparam logic [11:0] FLOOR_RGB_DEF = 12'hFFF;

  // ROM address of a block: row in the upper bits, column in the low 6 bits.
  function automatic logic [10:0] blk_addr(input logic [5:0] col, input logic [5:0] row);
    return {row[4:0], col};
  endfunction

endpackage

// File: rtl/maze_controller_if.sv
// Maze ROM port-b bus: controller drives enable/address, ROM returns data a cycle later.
interface maze_controller_if;
  logic        rom_en;
  logic [10:0] rom_addr;
  logic [15:0] rom_data;

  modport master (output rom_en, output rom_addr, input  rom_data);
  modport slave  (input  rom_en, input  rom_addr, output rom_data);
endinterface

// File: rtl/maze_controller.sv
// Player movement FSM: decodes one button press into one ROM lookup and moves
// the player only onto floor blocks; flags a win at the exit block.
module maze_controller
  import maze_pkg::*;
#(
  parameter int          START_BCOL = 1,
  parameter int          START_BROW = 1,
  parameter int          EXIT_BCOL  = 38,
  parameter int          EXIT_BROW  = 27,
  parameter logic [11:0] FLOOR_RGB  = FLOOR_RGB_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_up,
  input  logic              i_down,
  input  logic              i_left,
  input  logic              i_right,
  maze_controller_if.master rom,
  output logic [5:0]        o_player_bcol,
  output logic [5:0]        o_player_brow,
  output logic [5:0]        o_exit_bcol,
  output logic [5:0]        o_exit_brow,
  output logic              o_win,
  output logic [7:0]        o_moves
);

  localparam logic [5:0] C_START_COL = 6'(START_BCOL);
  localparam logic [5:0] C_START_ROW = 6'(START_BROW);
  localparam logic [5:0] C_EXIT_COL  = 6'(EXIT_BCOL);
  localparam logic [5:0] C_EXIT_ROW  = 6'(EXIT_BROW);
  localparam logic [5:0] C_MAX_COL   = 6'(VIS_BCOLS - 1);
  localparam logic [5:0] C_MAX_ROW   = 6'(PLAY_BROWS - 1);

  maze_state_t r_state;
  logic [5:0]  r_col, r_row;
  logic [5:0]  r_tcol, r_trow;
  logic        r_rom_en;
  logic [10:0] r_rom_addr;
  logic        r_win;
  logic [7:0]  r_moves;

  logic        w_any;
  logic        w_ok;
  logic [5:0]  w_tcol, w_trow;
  logic        w_floor;

  assign w_any = i_up | i_down | i_left | i_right;
  // Whole word compared so the low (non-colour) bits are explicitly don't-care.
  assign w_floor = ((rom.rom_data >> BLOCK_SHIFT) == {4'b0, FLOOR_RGB});

  // Target block of the highest-priority pressed direction, with range check.
  always_comb begin
    w_tcol = r_col;
    w_trow = r_row;
    w_ok   = 1'b1;
    if (i_up) begin
      if (r_row == 6'd0) w_ok = 1'b0;
      else               w_trow = r_row - 6'd1;
    end else if (i_down) begin
      if (r_row >= C_MAX_ROW) w_ok = 1'b0;
      else                    w_trow = r_row + 6'd1;
    end else if (i_left) begin
      if (r_col == 6'd0) w_ok = 1'b0;
      else               w_tcol = r_col - 6'd1;
    end else if (i_right) begin
      if (r_col >= C_MAX_COL) w_ok = 1'b0;
      else                    w_tcol = r_col + 6'd1;
    end
  end

  // Main FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_col      <= C_START_COL;
      r_row      <= C_START_ROW;
      r_tcol     <= 6'd0;
      r_trow     <= 6'd0;
      r_rom_en   <= 1'b0;
      r_rom_addr <= 11'd0;
      r_win      <= 1'b0;
      r_moves    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) r_state <= S_PLAY;
        end
        S_PLAY: begin
          if (w_any) begin
            if (w_ok) begin
              r_tcol     <= w_tcol;
              r_trow     <= w_trow;
              r_rom_en   <= 1'b1;
              r_rom_addr <= blk_addr(w_tcol, w_trow);
              r_state    <= S_READ;
            end else begin
              r_state <= S_RELEASE;
            end
          end
        end
        S_READ: begin
          // ROM captured the address at this edge; data is valid next cycle.
          r_rom_en <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (w_floor) begin
            r_col <= r_tcol;
            r_row <= r_trow;
            if (r_moves != 8'hFF) r_moves <= r_moves + 8'd1;
            if (r_tcol == C_EXIT_COL && r_trow == C_EXIT_ROW) begin
              r_win   <= 1'b1;
              r_state <= S_WIN;
            end else begin
              r_state <= S_RELEASE;
            end
          end else begin
            r_state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // One move per press: wait for every direction to be let go.
          if (!w_any) r_state <= S_PLAY;
        end
        S_WIN: begin
          if (i_start) begin
            r_col   <= C_START_COL;
            r_row   <= C_START_ROW;
            r_moves <= 8'd0;
            r_win   <= 1'b0;
            r_state <= S_PLAY;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom.rom_en    = r_rom_en;
  assign rom.rom_addr  = r_rom_addr;
  assign o_player_bcol = r_col;
  assign o_player_brow = r_row;
  assign o_exit_bcol   = C_EXIT_COL;
  assign o_exit_brow   = C_EXIT_ROW;
  assign o_win         = r_win;
  assign o_moves       = r_moves;

endmodule
